// File: rtl/binary_logic_pkg.sv
// Shared definitions for the BinaryLogic group: BIST sequencer states and defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package binary_logic_pkg;

  localparam int BL_WIDTH    = 4;
  localparam int BIST_SETTLE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/not_golden.sv
// Golden reference for the inverter: expected = ~a.
// Latency: combinational.
// Backpressure: none.
module not_golden #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] expected
);

  // Reference function kept separate so the sequencer can be reused for other units.
  always_comb begin
    expected = ~a;
  end

endmodule

// File: rtl/not_bist.sv
// BIST sequencer: sweeps every operand into the inverter and checks each result.
// Latency: SETTLE+1 cycles per pattern, 2^WIDTH*(SETTLE+1) cycles per sweep.
// Backpressure: none; start is ignored while a sweep is running.
module not_bist
  import binary_logic_pkg::*;
#(
  parameter int WIDTH  = BL_WIDTH,
  parameter int SETTLE = BIST_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail_a
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  bist_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;

  logic [WIDTH-1:0] expected;
  logic             mismatch;

  not_golden #(.WIDTH(WIDTH)) u_golden (
    .a        (a_q),
    .expected (expected)
  );

  assign mismatch = (dut_result != expected);

  // Next-state logic for the sweep: launch, settle, compare, terminate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fv_d    = fv_q;
    ffa_d   = ffa_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffa_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = RELOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + (WIDTH+1)'(1);
          if (!fv_q) begin
            ffa_d = a_q;
            fv_d  = 1'b1;
          end
        end
        if (&a_q) begin
          // Final pattern: the verdict includes the check just made.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          a_d     = a_q + 1'b1;
          cnt_d   = RELOAD;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wipes any partial sweep results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      ffa_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      ffa_q   <= ffa_d;
    end
  end

  assign dut_a        = a_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_valid   = fv_q;
  assign first_fail_a = ffa_q;

endmodule

// File: tb/tb_not_bist.sv
// Bench for not_bist: directed sweeps against good and faulty inverter models.
// Expected verdicts are queued at start; a monitor checks them when done rises.
module tb_not_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dut_a;
  logic [3:0] dut_result;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] first_fail_a;

  int mode;   // 0: good inverter, 1: result[0] stuck at 0, 2: single fault at a=9
  int cyc;    // number of rising edges so far
  int total;
  int bad;

  typedef struct {
    int         done_edge;
    logic [4:0] err;
    logic [3:0] ffa;
    logic       fv;
    logic       pass;
  } exp_t;

  exp_t exp_q[$];
  logic done_prev;

  not_bist dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dut_a        (dut_a),
    .dut_result   (dut_result),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .fail_valid   (fail_valid),
    .first_fail_a (first_fail_a)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (mode)
      1:       dut_result = (~dut_a) & 4'b1110;
      2:       dut_result = (dut_a == 4'b1001) ? 4'b0000 : ~dut_a;
      default: dut_result = ~dut_a;
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the expected verdict whenever done rises.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) begin
        total++;
        bad++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both (edge %0d)", cyc);
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done at edge %0d expected none", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_edge", cyc, e.done_edge);
          check("err_count", err_count, e.err);
          check("first_fail_a", first_fail_a, e.ffa);
          check("fail_valid", fail_valid, e.fv);
          check("pass", pass, e.pass);
          check("dut_a_final", dut_a, 15);
          check("busy_at_done", busy, 0);
        end
      end
    end
    done_prev = done;
  end

  // Pulse start so it is sampled at the next edge; returns that edge number.
  task automatic pulse_start(output int se);
    @(negedge clk);
    start = 1'b1;
    se = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input int se, input int err, input int ffa, input int fv, input int ps);
    exp_t e;
    e.done_edge = se + 48;
    e.err  = 5'(err);
    e.ffa  = 4'(ffa);
    e.fv   = fv[0];
    e.pass = ps[0];
    exp_q.push_back(e);
  endtask

  task automatic goto_negedge_at(input int edge_n);
    while (cyc < edge_n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending verdicts expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int se;
    cyc = 0;
    total = 0;
    bad = 0;
    mode = 0;
    done_prev = 1'b0;
    rst = 1'b1;
    start = 1'b1;   // must be ignored while in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dut_a", dut_a, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_ffa", first_fail_a, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Clean sweep
    mode = 0;
    pulse_start(se);
    push_exp(se, 0, 0, 0, 1);
    check("clean_busy_after_start", busy, 1);
    check("clean_dut_a_start", dut_a, 0);
    goto_negedge_at(se + 47);
    check("clean_busy_edge47", busy, 1);
    drain("clean");
    repeat (3) @(negedge clk);
    check("done_held", done, 1);
    check("pass_held", pass, 1);

    // Stuck bit, started from DONE
    mode = 1;
    pulse_start(se);
    push_exp(se, 8, 0, 1, 0);
    check("stuck_clear_err", err_count, 0);
    check("stuck_clear_done", done, 0);
    drain("stuck");

    // Single fault at a=9
    mode = 2;
    pulse_start(se);
    push_exp(se, 1, 9, 1, 0);
    drain("single");

    // Start pulses while busy are ignored
    mode = 0;
    pulse_start(se);
    push_exp(se, 0, 0, 0, 1);
    goto_negedge_at(se + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    goto_negedge_at(se + 19);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_start_dut_a", dut_a, 6);
    drain("busy_start");

    // Reset mid-sweep, with errors already accumulated
    mode = 1;
    pulse_start(se);
    goto_negedge_at(se + 29);
    check("mid_err_before_rst", err_count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_fv", fail_valid, 0);
    check("mid_rst_dut_a", dut_a, 0);
    @(negedge clk);
    check("mid_rst_idle", busy, 0);

    // Restart, complete, then restart again from DONE
    mode = 0;
    pulse_start(se);
    push_exp(se, 0, 0, 0, 1);
    drain("restart1");
    mode = 2;
    pulse_start(se);
    push_exp(se, 1, 9, 1, 0);
    check("restart2_busy", busy, 1);
    check("restart2_done", done, 0);
    check("restart2_pass", pass, 0);
    drain("restart2");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/not_bist.md
# not_bist

Built-in self-test sequencer for the bitwise inverter (`not_test`). The block drives every operand pattern into the inverter's `a` input and reads back its `result`, then compares each result against the golden inverse. It reports a pass/fail verdict, the error count and the first failing operand. It sits beside the inverter inside the BinaryLogic group and replaces the manual stimulus-and-display bench flow with a hardware checker that runs in simulation and in synthesis.

## Interface
- `WIDTH`, default 4: operand width; patterns swept = 2^WIDTH.
- `SETTLE`, default 2: wait cycles between driving `dut_a` and sampling `dut_result`; legal range ≥ 1.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `dut_a` output WIDTH: operand driven to the inverter's `a`; registered.
- `dut_result` input WIDTH: the inverter's `result`.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high from sweep completion until the next start or reset.
- `pass` output 1: valid when `done`=1; equals 1 iff `err_count`==0.
- `err_count` output WIDTH+1: number of mismatching patterns, saturation-free because the maximum is 2^WIDTH.
- `fail_valid` output 1: at least one mismatch has been captured.
- `first_fail_a` output WIDTH: operand of the first mismatch.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- Reset values: state=IDLE; `dut_a`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `first_fail_a` are all 0; the wait counter is 0.
- **IDLE, start=1:**
  - `dut_a`←0, `err_count`←0, `fail_valid`←0, `first_fail_a`←0.
  - `busy`←1, `done`←0, `pass`←0.
  - Wait counter←SETTLE−1, then go to WAIT.
- **WAIT:**
  - Decrement the wait counter.
  - When the counter is 0, go to CHECK.
  - `dut_a` is held constant.
- **CHECK** compares `dut_result` with `~dut_a` (expected value is the bitwise inverse, all WIDTH bits):
  - On mismatch: `err_count`+1. If `fail_valid`=0, then `first_fail_a`←`dut_a` and `fail_valid`←1.
  - If `dut_a`==all-ones: go to DONE with `busy`←0, `done`←1, and `pass`←(no errors, including this check).
  - Otherwise: `dut_a`←`dut_a`+1, reload the wait counter with SETTLE−1, and go to WAIT.
- **DONE:**
  - Outputs are held.
  - start=1 behaves exactly like start in IDLE: all results clear and a new sweep begins.
- `start` while in WAIT or CHECK is ignored; it does not restart or extend the sweep.
- Reset in any state, including mid-sweep, returns to IDLE with all outputs at their reset values on the next edge. No partial results survive.
- `dut_a` wraps only at the final pattern, which terminates the sweep; `dut_a` never returns to 0 while busy.

## Timing
- Each pattern occupies SETTLE+1 cycles: SETTLE WAIT cycles plus 1 CHECK cycle.
- Edge 0 is the edge that samples start. `dut_a`=0 is visible after edge 0.
- Pattern k is sampled at the CHECK edge, edge (k+1)(SETTLE+1).
- `done` rises, and `busy` falls, after edge 2^WIDTH·(SETTLE+1). With the defaults this is edge 48.
- `busy` and `done` are never high in the same cycle.
- `dut_result` is treated as combinational or registered logic with latency ≤ SETTLE−1 cycles.

## Structure
- Shared package `binary_logic_pkg`:
  - state enum (IDLE, WAIT, CHECK, DONE);
  - defaults `BL_WIDTH`=4 and `BIST_SETTLE`=2.
- One sub-module, `not_golden`: combinational `expected = ~a`. It isolates the reference function so the sequencer can be reused for the AND/OR/XOR units.
- The wait counter is $clog2(SETTLE+1) bits wide.

## Test plan
- **Reset:** hold `rst` for 2 cycles → every output is 0 and state is IDLE. `start` asserted together with `rst` is ignored.
- **Clean sweep:** correct inverter model, defaults, pulse `start` → `busy`=1 from edge 0 until edge 48, then `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0, `dut_a`=4'b1111.
- **Stuck bit:** inverter with `result[0]` stuck at 0 → `err_count`=8 (all even `a`), `first_fail_a`=4'b0000, `fail_valid`=1, `pass`=0.
- **Single fault:** model returns 4'b0000 only for `a`=4'b1001 (expected 4'b0110) → `err_count`=1, `first_fail_a`=4'b1001, `pass`=0.
- **Start while busy:** pulse `start` at edges 5 and 20 → ignored; `done` still rises after edge 48.
- **Reset and restart:** assert `rst` at edge 30 mid-sweep → next edge `busy`=0 and `err_count`=0. Then start, complete, and start again from DONE → results cleared at the start edge, and the second sweep finishes 48 edges later.
